// File: rtl/hour12_clock_ctrl_pkg.sv
// Shared types and constants for the 12-hour clock controller.
// Provides the FSM state enum, BCD/digit-index types and the segment patterns.
package clk12_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;
    typedef logic [2:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for BCD 0..9.
    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/hour12_clock_ctrl_if.sv
// Pushbutton/control inputs and display outputs of the 12-hour clock controller.
// The bench drives through master; the controller implements slave.
interface hour12_clock_ctrl_if;

    logic       en;
    logic       speed;
    logic       btn_mode;
    logic       btn_inc;
    logic [6:0] seg;
    logic [5:0] an;
    logic       pm;
    logic [1:0] mode;

    modport master (
        output en, speed, btn_mode, btn_inc,
        input  seg, an, pm, mode
    );

    modport slave (
        input  en, speed, btn_mode, btn_inc,
        output seg, an, pm, mode
    );

endinterface

// File: rtl/hour12_clock_ctrl_seg7_decoder.sv
// Shared BCD to active-low seven-segment decoder with a blank override.
// Values above 9 are shown blank rather than as garbage patterns.
module seg7_decoder
    import clk12_pkg::*;
(
    input  bcd_t       i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank && (i_bcd <= 4'd9)) begin
            o_seg = SEG_TABLE[i_bcd];
        end
    end

endmodule

// File: rtl/hour12_clock_ctrl.sv
// 12-hour BCD clock: tick prescaler, RUN/SET_HR/SET_MIN FSM, six-digit scan mux.
// Define BLINK_EN to blink the digits being edited in the SET states.
module hour12_clock_ctrl
    import clk12_pkg::*;
#(
    parameter int SEC_DIV   = 100_000_000,
    parameter int FAST_DIV  = 1_000_000,
    parameter int SCAN_DIV  = 16_667,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    hour12_clock_ctrl_if.slave   bus
);

    localparam int PRESC_MAX = (SEC_DIV > FAST_DIV) ? SEC_DIV : FAST_DIV;
    localparam int PRESC_W   = (PRESC_MAX > 1) ? $clog2(PRESC_MAX) : 1;
    localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    function automatic logic [7:0] inc_mod60(input bcd_t t, input bcd_t u);
        if (u != 4'd9) return {t, u + 4'd1};
        if (t != 4'd5) return {t + 4'd1, 4'd0};
        return 8'h00;
    endfunction

    function automatic logic [7:0] inc_hour12(input bcd_t t, input bcd_t u);
        if (t == 4'd1 && u == 4'd2) return 8'h01;
        if (u == 4'd9) return 8'h10;
        return {t, u + 4'd1};
    endfunction

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_count;
    logic               w_set_hr_inc;
    logic               w_set_min_inc;
    logic               w_leave_min;

    logic [PRESC_W-1:0] r_presc;
    logic               r_tick;
    logic               r_speed_d;
    logic [PRESC_W-1:0] w_div_last;
    logic               w_presc_term;
    logic               w_speed_chg;

    bcd_t               r_sec_t, r_sec_u, r_min_t, r_min_u, r_hr_t, r_hr_u;
    logic               r_pm;
    logic               w_run_tick;
    logic               w_sec_wrap;
    logic               w_min_wrap;
    logic               w_min_step;
    logic               w_hr_step;

    logic [SCAN_W-1:0]  r_scan_cnt;
    digit_idx_t         r_idx;
    logic [5:0]         r_an;
    logic [6:0]         r_seg;
    bcd_t               w_digit;
    logic               w_blank;
    logic               w_blink_blank;
    logic [6:0]         w_seg;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= RUN;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.btn_mode) begin
            case (r_state)
                RUN:     w_state_nxt = SET_HR;
                SET_HR:  w_state_nxt = SET_MIN;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // A mode press in the same cycle as inc always wins, so inc is masked here.
    always_comb begin
        w_count       = 1'b0;
        w_set_hr_inc  = 1'b0;
        w_set_min_inc = 1'b0;
        w_leave_min   = 1'b0;
        case (r_state)
            RUN:     w_count       = bus.en;
            SET_HR:  w_set_hr_inc  = bus.btn_inc && !bus.btn_mode;
            SET_MIN: begin
                w_set_min_inc = bus.btn_inc && !bus.btn_mode;
                w_leave_min   = bus.btn_mode;
            end
            default: ;
        endcase
    end

    assign w_div_last   = bus.speed ? PRESC_W'(FAST_DIV - 1) : PRESC_W'(SEC_DIV - 1);
    assign w_presc_term = (r_presc == w_div_last);
    assign w_speed_chg  = (bus.speed != r_speed_d);

    always_ff @(posedge clk) begin
        r_speed_d <= bus.speed;
        if (!rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_count && w_presc_term && !w_speed_chg;
            if (w_speed_chg || w_leave_min) r_presc <= '0;
            else if (w_count)                r_presc <= w_presc_term ? '0 : r_presc + 1'b1;
        end
    end

    assign w_run_tick = w_count && r_tick;
    assign w_sec_wrap = (r_sec_t == 4'd5) && (r_sec_u == 4'd9);
    assign w_min_wrap = (r_min_t == 4'd5) && (r_min_u == 4'd9);
    assign w_min_step = (w_run_tick && w_sec_wrap) || w_set_min_inc;
    assign w_hr_step  = (w_run_tick && w_sec_wrap && w_min_wrap) || w_set_hr_inc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            {r_sec_t, r_sec_u} <= 8'h00;
            {r_min_t, r_min_u} <= 8'h00;
            {r_hr_t, r_hr_u}   <= 8'h12;
            r_pm               <= 1'b0;
        end else begin
            if (w_run_tick)       {r_sec_t, r_sec_u} <= inc_mod60(r_sec_t, r_sec_u);
            else if (w_leave_min) {r_sec_t, r_sec_u} <= 8'h00;
            if (w_min_step)       {r_min_t, r_min_u} <= inc_mod60(r_min_t, r_min_u);
            if (w_hr_step) begin
                {r_hr_t, r_hr_u} <= inc_hour12(r_hr_t, r_hr_u);
                if (r_hr_t == 4'd1 && r_hr_u == 4'd1) r_pm <= ~r_pm;
            end
        end
    end

`ifdef BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;

    // Any inc restarts the phase so the freshly edited value is visible at once.
    always_ff @(posedge clk) begin
        if (!rst || bus.btn_inc) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blink_blank = r_blink_phase &&
        (((r_state == SET_HR)  && (r_idx == 3'd4 || r_idx == 3'd5)) ||
         ((r_state == SET_MIN) && (r_idx == 3'd2 || r_idx == 3'd3)));
`else
    assign w_blink_blank = 1'b0 && (BLINK_DIV > 0);
`endif

    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            3'd0:    w_digit = r_sec_u;
            3'd1:    w_digit = r_sec_t;
            3'd2:    w_digit = r_min_u;
            3'd3:    w_digit = r_min_t;
            3'd4:    w_digit = r_hr_u;
            3'd5:    w_digit = r_hr_t;
            default: w_digit = 4'd0;
        endcase
    end

    assign w_blank = ((r_idx == 3'd5) && (r_hr_t == 4'd0)) || w_blink_blank;

    seg7_decoder u_dec (
        .i_bcd   (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 3'd0;
            r_an       <= 6'h3F;
            r_seg      <= SEG_BLANK;
        end else begin
            if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_an  <= ~(6'b000001 << r_idx);
            r_seg <= w_seg;
        end
    end

    assign bus.seg  = r_seg;
    assign bus.an   = r_an;
    assign bus.pm   = r_pm;
    assign bus.mode = r_state;

endmodule

// File: tb/tb_hour12_clock_ctrl.sv
// Bench for hour12_clock_ctrl: directed scenarios plus random button/en/speed traffic,
// checked every cycle against an arithmetic time-of-day model with pinned literals.
module tb_hour12_clock_ctrl;

    localparam int SEC_DIV   = 10;
    localparam int FAST_DIV  = 2;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hour12_clock_ctrl_if bus();

    hour12_clock_ctrl #(
        .SEC_DIV   (SEC_DIV),
        .FAST_DIV  (FAST_DIV),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: plain integers for the time of day.
    int         m_hr, m_min, m_sec, m_presc, m_scnt, m_idx, m_bcnt;
    bit         m_pm, m_tick, m_spd_d, m_phase, m_started;
    logic [1:0] m_state;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic [6:0] hi_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic hour_step();
        m_hr = m_hr % 12 + 1;
        if (m_hr == 12) m_pm = ~m_pm;
    endtask

    always @(posedge clk) begin : model
        int d, div;
        bit blank, chg, run, ntick;
        m_started = 1'b1;
        if (!rst) begin
            m_hr = 12; m_min = 0; m_sec = 0; m_pm = 0; m_state = 2'd0;
            m_presc = 0; m_tick = 0; m_scnt = 0; m_idx = 0; m_bcnt = 0; m_phase = 0;
            m_spd_d = bus.speed;
            e_an = 6'h3F; e_seg = 7'h7F;
        end else begin
            case (m_idx)
                0: d = m_sec % 10;
                1: d = m_sec / 10;
                2: d = m_min % 10;
                3: d = m_min / 10;
                4: d = m_hr % 10;
                default: d = m_hr / 10;
            endcase
            blank = (m_idx == 5) && (m_hr < 10);
`ifdef BLINK_EN
            if (m_phase && ((m_state == 2'd1 && m_idx >= 4) || (m_state == 2'd2 && (m_idx == 2 || m_idx == 3))))
                blank = 1'b1;
`endif
            e_an  = 6'h3F ^ (6'h01 << m_idx);
            e_seg = blank ? 7'h7F : ~hi_tab[d];

            run = (m_state == 2'd0) && bus.en;
            if (run && m_tick) begin
                m_sec++;
                if (m_sec == 60) begin
                    m_sec = 0;
                    m_min++;
                    if (m_min == 60) begin
                        m_min = 0;
                        hour_step();
                    end
                end
            end
            if (m_state == 2'd1 && bus.btn_inc && !bus.btn_mode) hour_step();
            if (m_state == 2'd2 && bus.btn_inc && !bus.btn_mode) m_min = (m_min + 1) % 60;
            if (m_state == 2'd2 && bus.btn_mode) m_sec = 0;

            div   = bus.speed ? FAST_DIV : SEC_DIV;
            chg   = (bus.speed != m_spd_d);
            ntick = run && !chg && (m_presc == div - 1);
            if (chg || (m_state == 2'd2 && bus.btn_mode)) m_presc = 0;
            else if (run) m_presc = (m_presc == div - 1) ? 0 : m_presc + 1;
            m_tick  = ntick;
            m_spd_d = bus.speed;

            if (bus.btn_mode) m_state = (m_state == 2'd2) ? 2'd0 : m_state + 2'd1;

            if (m_scnt == SCAN_DIV - 1) begin
                m_scnt = 0;
                m_idx  = (m_idx + 1) % 6;
            end else begin
                m_scnt++;
            end
`ifdef BLINK_EN
            if (bus.btn_inc) begin
                m_bcnt = 0; m_phase = 0;
            end else if (m_bcnt == BLINK_DIV - 1) begin
                m_bcnt = 0; m_phase = ~m_phase;
            end else begin
                m_bcnt++;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            checks++;
            if (bus.an !== e_an || bus.seg !== e_seg || bus.pm !== m_pm || bus.mode !== m_state) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL cycle_cmp t=%0t an=%h/%h seg=%h/%h pm=%b/%b mode=%0d/%0d (got/want)",
                             $time, bus.an, e_an, bus.seg, e_seg, bus.pm, m_pm, bus.mode, m_state);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic press_mode();
        @(negedge clk); bus.btn_mode = 1'b1;
        @(negedge clk); bus.btn_mode = 1'b0;
    endtask

    task automatic press_inc();
        @(negedge clk); bus.btn_inc = 1'b1;
        @(negedge clk); bus.btn_inc = 1'b0;
    endtask

    task automatic wait_idx(input int k);
        logic [5:0] want;
        want = 6'h3F ^ (6'h01 << k);
        for (int i = 0; i < 40; i++) begin
            if (bus.an === want) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL wait_idx%0d an=%h want=%h", k, bus.an, want);
    endtask

    task automatic set_time(input int h, input int m);
        press_mode();
        for (int i = 0; i < 12 && m_hr != h; i++) press_inc();
        press_mode();
        for (int i = 0; i < 60 && m_min != m; i++) press_inc();
        press_mode();
    endtask

    task automatic wait_sec(input int s, input string name);
        int n;
        n = 0;
        while (m_sec != s && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, m_sec, s);
    endtask

    logic [5:0] walk_an  [0:5] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    logic [6:0] walk_seg [0:5] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h79};

    initial begin
        logic [5:0] seen;
        int n;
        bus.en = 1'b0; bus.speed = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;

        // Reset and scan walk at 12:00:00 AM with time frozen.
        repeat (3) @(negedge clk);
        check("rst_an", bus.an, 6'h3F);
        check("rst_seg", bus.seg, 7'h7F);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("walk_an%0d", i), bus.an, walk_an[i]);
            check($sformatf("walk_seg%0d", i), bus.seg, walk_seg[i]);
            repeat (SCAN_DIV) @(negedge clk);
        end
        check("rst_pm", bus.pm, 1'b0);
        check("rst_mode", bus.mode, 2'd0);

        // Setting hours and minutes.
        press_mode();
        check("mode_set_hr", bus.mode, 2'd1);
        repeat (3) press_inc();
        check("model_hr3", m_hr, 3);
        check("pm_after_12_to_3", bus.pm, 1'b0);
        press_mode();
        check("mode_set_min", bus.mode, 2'd2);
        repeat (59) press_inc();
        check("model_min59", m_min, 59);
        press_inc();
        check("model_min_wrap", m_min, 0);
        check("model_hr_no_carry", m_hr, 3);
        press_mode();
        check("mode_run", bus.mode, 2'd0);
        check("model_sec_clr", m_sec, 0);
        wait_idx(4); check("disp_hr_u3", bus.seg, 7'h30);
        wait_idx(5); check("disp_hr_t_blank", bus.seg, 7'h7F);
        wait_idx(2); check("disp_min_u0", bus.seg, 7'h40);

        // Simultaneous mode+inc: mode wins.
        press_mode();
        @(negedge clk); bus.btn_mode = 1'b1; bus.btn_inc = 1'b1;
        @(negedge clk); bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
        check("mode_both", bus.mode, 2'd2);
        check("model_hr_both", m_hr, 3);
        press_mode();
        wait_idx(4); check("disp_hr_both", bus.seg, 7'h30);

        // Frozen time keeps scanning.
        seen = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            for (int k = 0; k < 6; k++)
                if (bus.an === (6'h3F ^ (6'h01 << k))) seen[k] = 1'b1;
        end
        check("scan_while_frozen", seen, 6'h3F);
        check("model_sec_frozen", m_sec, 0);
        wait_idx(0); check("disp_sec_u0", bus.seg, 7'h40);

        // Speed change clears the prescaler; fast period is 2 cycles.
        bus.en = 1'b1;
        n = 0;
        while (m_presc != 1 && n < 40) begin @(negedge clk); n++; end
        check("presc_at1", m_presc, 1);
        bus.speed = 1'b1;
        @(negedge clk);
        check("presc_cleared", m_presc, 0);
        n = 0;
        while (!m_tick && n < 20) begin @(negedge clk); n++; end
        check("first_fast_tick", n, 2);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_tick && n < 20);
        check("fast_period", n, 2);

        // Rollovers.
        set_time(11, 59);
        check("pm_before_noon", bus.pm, 1'b0);
        wait_sec(59, "reach_11_59_59");
        wait_sec(0, "reach_noon");
        check("model_hr12", m_hr, 12);
        check("model_min0", m_min, 0);
        check("pm_noon", bus.pm, 1'b1);
        wait_idx(4); check("disp_noon_u", bus.seg, 7'h24);
        wait_idx(5); check("disp_noon_t", bus.seg, 7'h79);
        set_time(12, 59);
        wait_sec(59, "reach_12_59_59");
        wait_sec(0, "reach_one");
        check("model_hr1", m_hr, 1);
        check("pm_one", bus.pm, 1'b1);
        wait_idx(5); check("disp_one_t_blank", bus.seg, 7'h7F);
        wait_idx(4); check("disp_one_u", bus.seg, 7'h79);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus.en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) bus.speed = ~bus.speed;
            bus.btn_mode = ($urandom_range(0, 39) == 0);
            bus.btn_inc  = ($urandom_range(0, 7) == 0);
            rst          = ($urandom_range(0, 1499) != 0);
        end
        @(negedge clk);
        rst = 1'b1; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
